// File: rtl/div_rem_ctrl.sv
// RV32M DIV/REM control stage: special-case bypass, divider handshake, shift-add REM fix-up.
// Optional DIV_REM_PAIR_CACHE_EN keeps the last {rs1, rs2, q} so a DIV/REM pair divides once.
module div_rem_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_in_valid_o,
  input  logic            div_in_ready_i,
  input  logic [XLEN-1:0] div_c_i,
  input  logic            div_out_valid_i,
  output logic            div_out_ready_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic [4:0]      rsp_rd_o,
  output logic            rsp_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_Q, MUL, RESP} state_e;

  state_e          state_q, state_d;
  logic            live_q;
  logic            rem_q, rem_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [XLEN-1:0] partial;

`ifdef DIV_REM_PAIR_CACHE_EN
  logic            cv_q, cv_d;
  logic [XLEN-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_q_q, c_q_d;
  logic            hit;
  assign hit = cv_q && (c_rs1_q == req_rs1_i) && (c_rs2_q == req_rs2_i);
`endif

  logic f3_rem, f3_bad, uns_err, rs2_zero, rs1_zero, ovf;
  assign f3_rem   = req_funct3_i[1];
  assign f3_bad   = !req_funct3_i[2];
  assign uns_err  = req_funct3_i[0] && (req_rs1_i[XLEN-1] || req_rs2_i[XLEN-1]);
  assign rs2_zero = (req_rs2_i == '0);
  assign rs1_zero = (req_rs1_i == '0);
  assign ovf      = (req_rs1_i == MIN_INT) && (req_rs2_i == '1);

  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    data_d   = data_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef DIV_REM_PAIR_CACHE_EN
    cv_d     = cv_q;
    c_rs1_d  = c_rs1_q;
    c_rs2_d  = c_rs2_q;
    c_q_d    = c_q_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && live_q) begin
          rs1_d   = req_rs1_i;
          rs2_d   = req_rs2_i;
          rd_d    = req_rd_i;
          rem_d   = f3_rem;
          err_d   = 1'b0;
          data_d  = '0;
          state_d = RESP;
          // Divide-by-zero is exact for the unsigned ops too, so it outranks the MSB check.
          if (rs2_zero) begin
            data_d = f3_rem ? req_rs1_i : '1;
          end else if (f3_bad || uns_err) begin
            err_d = 1'b1;
`ifdef DIV_REM_PAIR_CACHE_EN
            cv_d  = 1'b0;
`endif
          end else if (ovf) begin
            data_d = f3_rem ? '0 : MIN_INT;
          end else if (rs1_zero) begin
            data_d = '0;
`ifdef DIV_REM_PAIR_CACHE_EN
          end else if (hit) begin
            if (f3_rem) begin
              acc_d    = '0;
              mcand_d  = req_rs2_i;
              mplier_d = c_q_q;
              cnt_d    = '0;
              state_d  = MUL;
            end else begin
              data_d = c_q_q;
            end
`endif
          end else begin
            tmo_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (div_in_ready_i) begin
          tmo_d   = '0;
          state_d = WAIT_Q;
        end
      end
      WAIT_Q: begin
        if (div_out_valid_i) begin
`ifdef DIV_REM_PAIR_CACHE_EN
          cv_d    = 1'b1;
          c_rs1_d = rs1_q;
          c_rs2_d = rs2_q;
          c_q_d   = div_c_i;
`endif
          if (rem_q) begin
            acc_d    = '0;
            mcand_d  = rs2_q;
            mplier_d = div_c_i;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            data_d  = div_c_i;
            state_d = RESP;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
`ifdef DIV_REM_PAIR_CACHE_EN
          cv_d    = 1'b0;
`endif
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first; the 32nd step folds in the subtract.
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          data_d  = rs1_q - partial;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      rem_q    <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      rem_q    <= rem_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

`ifdef DIV_REM_PAIR_CACHE_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cv_q    <= 1'b0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_q_q   <= '0;
    end else begin
      cv_q    <= cv_d;
      c_rs1_q <= c_rs1_d;
      c_rs2_q <= c_rs2_d;
      c_q_q   <= c_q_d;
    end
  end
`endif

  // live_q keeps req_ready_o low until the first clock after reset release.
  assign req_ready_o     = (state_q == IDLE) && live_q;
  assign div_in_valid_o  = (state_q == ISSUE);
  assign div_out_ready_o = (state_q == WAIT_Q);
  assign rsp_valid_o     = (state_q == RESP);
  assign div_a_o         = rs1_q;
  assign div_b_o         = rs2_q;
  assign rsp_data_o      = data_q;
  assign rsp_rd_o        = rd_q;
  assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_div_rem_ctrl.sv
// Directed bench for div_rem_ctrl; the divider side is driven by hand step by step.
module tb_div_rem_ctrl;
  logic        clock = 1'b0;
  logic        nreset;
  logic        req_valid_i, req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_rs1_i, req_rs2_i;
  logic [4:0]  req_rd_i;
  logic [31:0] div_a_o, div_b_o, div_c_i, rsp_data_o;
  logic        div_in_valid_o, div_in_ready_i, div_out_valid_i, div_out_ready_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [4:0]  rsp_rd_o;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110;

  div_rem_ctrl dut (
    .clock(clock), .nreset(nreset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_in_valid_o(div_in_valid_o),
    .div_in_ready_i(div_in_ready_i), .div_c_i(div_c_i), .div_out_valid_i(div_out_valid_i),
    .div_out_ready_o(div_out_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    req_valid_i = 1'b1; req_funct3_i = f3; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
    step();
    req_valid_i = 1'b0;
    $display("req f3=%b rs1=%h rs2=%h rd=%0d", f3, a, b, rd);
  endtask

  task automatic issue_and_return(input logic [31:0] q);
    div_in_ready_i = 1'b1;
    step();
    div_in_ready_i = 1'b0;
    div_out_valid_i = 1'b1; div_c_i = q;
    step();
    div_out_valid_i = 1'b0; div_c_i = '0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] data, input logic err,
                            input logic [4:0] rd);
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, "_data"}, rsp_data_o, data);
    check({tag, "_err"}, 32'(rsp_err_o), 32'(err));
    check({tag, "_rd"}, 32'(rsp_rd_o), 32'(rd));
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, "_idle_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_rsp_drop"}, 32'(rsp_valid_o), 32'd0);
    $display("rsp %s data=%h err=%0d rd=%0d", tag, rsp_data_o, rsp_err_o, rsp_rd_o);
  endtask

  initial begin
    int n;
    int seen;
    nreset = 1'b0; req_valid_i = 1'b0; req_funct3_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_rd_i = '0; div_in_ready_i = 1'b0; div_c_i = '0; div_out_valid_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_div_in_valid", 32'(div_in_valid_o), 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    nreset = 1'b1;
    step();
    check("post_rst_ready", 32'(req_ready_o), 32'd1);

    // DIV 100/7 through the divider
    do_req(F_DIV, 32'd100, 32'd7, 5'd3);
    check("div_in_valid", 32'(div_in_valid_o), 32'd1);
    check("div_a", div_a_o, 32'd100);
    check("div_b", div_b_o, 32'd7);
    check("busy_not_ready", 32'(req_ready_o), 32'd0);
    div_in_ready_i = 1'b1;
    step();
    div_in_ready_i = 1'b0;
    check("in_valid_drop", 32'(div_in_valid_o), 32'd0);
    check("out_ready", 32'(div_out_ready_o), 32'd1);
    div_out_valid_i = 1'b1; div_c_i = 32'd14;
    step();
    div_out_valid_i = 1'b0;
    finish_rsp("div100_7", 32'd14, 1'b0, 5'd3);

    // REM -100/7: quotient -14, 32 MUL cycles
    do_req(F_REM, 32'hFFFF_FF9C, 32'd7, 5'd5);
    issue_and_return(32'hFFFF_FFF2);
    wait_rsp(n);
    check("rem_mul_cycles", 32'(n), 32'd32);
    finish_rsp("rem_m100_7", 32'hFFFF_FFFE, 1'b0, 5'd5);

    // Divide-by-zero bypass
    do_req(F_DIV, 32'd5, 32'd0, 5'd1);
    check("dz_in_valid", 32'(div_in_valid_o), 32'd0);
    finish_rsp("div5_0", 32'hFFFF_FFFF, 1'b0, 5'd1);
    do_req(F_REM, 32'd5, 32'd0, 5'd2);
    check("rz_in_valid", 32'(div_in_valid_o), 32'd0);
    finish_rsp("rem5_0", 32'd5, 1'b0, 5'd2);

    // Signed overflow bypass
    do_req(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    check("ovf_in_valid", 32'(div_in_valid_o), 32'd0);
    finish_rsp("div_ovf", 32'h8000_0000, 1'b0, 5'd4);
    do_req(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    finish_rsp("rem_ovf", 32'd0, 1'b0, 5'd6);

    // Zero dividend and unsigned MSB error
    do_req(F_DIV, 32'd0, 32'd9, 5'd8);
    finish_rsp("div0_9", 32'd0, 1'b0, 5'd8);
    do_req(F_DIVU, 32'h8000_0001, 32'd3, 5'd10);
    finish_rsp("divu_msb", 32'd0, 1'b1, 5'd10);

    // Backpressure on both handshakes
    do_req(F_DIV, 32'd1000, 32'd10, 5'd7);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_valid", 32'(div_in_valid_o), 32'd1);
      check("bp_a", div_a_o, 32'd1000);
      check("bp_b", div_b_o, 32'd10);
      step();
    end
    issue_and_return(32'd100);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_rsp_data", rsp_data_o, 32'd100);
      step();
    end
    finish_rsp("bp_div", 32'd100, 1'b0, 5'd7);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o) seen++;
      step();
    end
    check("bp_single_rsp", 32'(seen), 32'd0);

    // Silent divider
    do_req(F_DIV, 32'd50, 32'd5, 5'd9);
    div_in_ready_i = 1'b1;
    step();
    div_in_ready_i = 1'b0;
    wait_rsp(n);
    check("tmo_cycles", 32'(n), 32'd128);
    check("tmo_out_ready", 32'(div_out_ready_o), 32'd0);
    finish_rsp("timeout", 32'd0, 1'b1, 5'd9);

    // Reset in the middle of MUL
    do_req(F_REM, 32'd100, 32'd7, 5'd11);
    issue_and_return(32'd14);
    repeat (10) step();
    nreset = 1'b0;
    #1;
    check("mr_req_ready", 32'(req_ready_o), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mr_rsp_data", rsp_data_o, 32'd0);
    check("mr_rsp_rd", 32'(rsp_rd_o), 32'd0);
    check("mr_div_a", div_a_o, 32'd0);
    check("mr_out_ready", 32'(div_out_ready_o), 32'd0);
    step();
    nreset = 1'b1;
    step();
    check("mr_ready_after", 32'(req_ready_o), 32'd1);
    check("mr_no_rsp", 32'(rsp_valid_o), 32'd0);

`ifdef DIV_REM_PAIR_CACHE_EN
    do_req(F_DIV, 32'd100, 32'd7, 5'd12);
    issue_and_return(32'd14);
    finish_rsp("cache_fill", 32'd14, 1'b0, 5'd12);
    do_req(F_REM, 32'd100, 32'd7, 5'd13);
    seen = 0;
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      if (div_in_valid_o) seen++;
      step();
      n++;
    end
    check("cache_no_issue", 32'(seen), 32'd0);
    check("cache_mul_cycles", 32'(n), 32'd32);
    finish_rsp("cache_rem", 32'd2, 1'b0, 5'd13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
